// File: rtl/id_exe_stage_pkg.sv
// Shared MIPS control encodings and the write-back address selection used by the ID/EXE register.
// The all-zero control word is a NOP: PC_NEXT, no memory access and no write-back.
package id_exe_stage_pkg;

    localparam logic [2:0] PC_NEXT = 3'd0;
    localparam logic [2:0] PC_JUMP = 3'd1;
    localparam logic [2:0] PC_JR   = 3'd2;
    localparam logic [2:0] PC_BEQ  = 3'd3;
    localparam logic [2:0] PC_BNE  = 3'd4;

    localparam logic [1:0] EXE_A_RS   = 2'd0;
    localparam logic [1:0] EXE_A_LINK = 2'd1;
    localparam logic [1:0] EXE_B_RT   = 2'd0;
    localparam logic [1:0] EXE_B_IMM  = 2'd1;

    localparam logic [3:0] EXE_ALU_ADD = 4'd0;
    localparam logic [3:0] EXE_ALU_SUB = 4'd1;
    localparam logic [3:0] EXE_ALU_AND = 4'd2;
    localparam logic [3:0] EXE_ALU_OR  = 4'd3;

    localparam logic [1:0] WB_ADDR_RD   = 2'd0;
    localparam logic [1:0] WB_ADDR_RT   = 2'd1;
    localparam logic [1:0] WB_ADDR_LINK = 2'd2;

    // Destination register for a given write-back address source; code 3 maps to r0.
    function automatic logic [4:0] regw_sel(input logic [1:0] src,
                                            input logic [31:0] inst,
                                            input logic [4:0] link_reg);
        logic [4:0] r;
        r = 5'd0;
        case (src)
            WB_ADDR_RD:   r = inst[15:11];
            WB_ADDR_RT:   r = inst[20:16];
            WB_ADDR_LINK: r = link_reg;
            default:      r = 5'd0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/id_exe_stage_sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
module sat_counter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    logic [WIDTH-1:0] r_count;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_count <= '0;
        end else if (clr) begin
            r_count <= '0;
        end else if (inc && (r_count != {WIDTH{1'b1}})) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign count = r_count;

endmodule

// File: rtl/id_exe_stage.sv
// ID/EXE pipeline register bank: captures decoded ID fields under controller enable/reset
// and returns EXE-stage hazard feedback plus bubble/hold debug counters.
module id_exe_stage
    import id_exe_stage_pkg::*;
#(
    parameter int CNT_WIDTH = 16,
    parameter int LINK_REG  = 31
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 stage_rst,
    input  logic                 stage_en,
    input  logic                 in_valid,
    input  logic [31:0]          in_inst,
    input  logic [31:0]          in_pc,
    input  logic [31:0]          in_data_rs,
    input  logic [31:0]          in_data_rt,
    input  logic [31:0]          in_data_imm,
    input  logic [2:0]           in_pc_src,
    input  logic [1:0]           in_exe_a_src,
    input  logic [1:0]           in_exe_b_src,
    input  logic [3:0]           in_exe_alu_oper,
    input  logic                 in_mem_ren,
    input  logic                 in_mem_wen,
    input  logic [1:0]           in_wb_addr_src,
    input  logic                 in_wb_data_src,
    input  logic                 in_wb_wen,
    input  logic                 cnt_clr,
    output logic [31:0]          out_inst,
    output logic [31:0]          out_pc,
    output logic [31:0]          out_data_rs,
    output logic [31:0]          out_data_rt,
    output logic [31:0]          out_data_imm,
    output logic [2:0]           out_pc_src,
    output logic [1:0]           out_exe_a_src,
    output logic [1:0]           out_exe_b_src,
    output logic [3:0]           out_exe_alu_oper,
    output logic                 out_mem_ren,
    output logic                 out_mem_wen,
    output logic [1:0]           out_wb_addr_src,
    output logic                 out_wb_data_src,
    output logic                 out_wb_wen,
    output logic                 exe_valid,
    output logic [4:0]           regw_addr_exe,
    output logic                 wb_wen_exe,
    output logic                 is_branch_exe,
    output logic [CNT_WIDTH-1:0] bubble_cnt,
    output logic [CNT_WIDTH-1:0] hold_cnt
);

    localparam logic [4:0] LINK_ADDR = 5'(LINK_REG);

    logic [4:0] w_regw_addr;
    logic       w_bubble_inc;
    logic       w_hold_inc;

    assign w_regw_addr  = regw_sel(in_wb_addr_src, in_inst, LINK_ADDR);
    assign w_bubble_inc = stage_rst | (stage_en & ~in_valid);
    assign w_hold_inc   = ~stage_rst & ~stage_en;

    // Stage reset loads a NOP bubble and takes priority over the enable.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_inst         <= '0;
            out_pc           <= '0;
            out_data_rs      <= '0;
            out_data_rt      <= '0;
            out_data_imm     <= '0;
            out_pc_src       <= PC_NEXT;
            out_exe_a_src    <= '0;
            out_exe_b_src    <= '0;
            out_exe_alu_oper <= '0;
            out_mem_ren      <= 1'b0;
            out_mem_wen      <= 1'b0;
            out_wb_addr_src  <= '0;
            out_wb_data_src  <= 1'b0;
            out_wb_wen       <= 1'b0;
            exe_valid        <= 1'b0;
            regw_addr_exe    <= '0;
        end else if (stage_rst) begin
            out_inst         <= '0;
            out_pc           <= '0;
            out_data_rs      <= '0;
            out_data_rt      <= '0;
            out_data_imm     <= '0;
            out_pc_src       <= PC_NEXT;
            out_exe_a_src    <= '0;
            out_exe_b_src    <= '0;
            out_exe_alu_oper <= '0;
            out_mem_ren      <= 1'b0;
            out_mem_wen      <= 1'b0;
            out_wb_addr_src  <= '0;
            out_wb_data_src  <= 1'b0;
            out_wb_wen       <= 1'b0;
            exe_valid        <= 1'b0;
            regw_addr_exe    <= '0;
        end else if (stage_en) begin
            out_inst         <= in_inst;
            out_pc           <= in_pc;
            out_data_rs      <= in_data_rs;
            out_data_rt      <= in_data_rt;
            out_data_imm     <= in_data_imm;
            out_pc_src       <= in_pc_src;
            out_exe_a_src    <= in_exe_a_src;
            out_exe_b_src    <= in_exe_b_src;
            out_exe_alu_oper <= in_exe_alu_oper;
            out_mem_ren      <= in_mem_ren;
            out_mem_wen      <= in_mem_wen;
            out_wb_addr_src  <= in_wb_addr_src;
            out_wb_data_src  <= in_wb_data_src;
            out_wb_wen       <= in_wb_wen;
            exe_valid        <= in_valid;
            regw_addr_exe    <= w_regw_addr;
        end
    end

    // Feedback is gated by valid so a captured-invalid entry never raises a hazard.
    assign wb_wen_exe    = exe_valid & out_wb_wen;
    assign is_branch_exe = exe_valid & (out_pc_src != PC_NEXT);

    sat_counter #(.WIDTH(CNT_WIDTH)) u_bubble_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr   (cnt_clr),
        .inc   (w_bubble_inc),
        .count (bubble_cnt)
    );

    sat_counter #(.WIDTH(CNT_WIDTH)) u_hold_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr   (cnt_clr),
        .inc   (w_hold_inc),
        .count (hold_cnt)
    );

endmodule

// File: tb/tb_id_exe_stage.sv
// Directed and randomized bench for id_exe_stage against a behavioural register-bank model.
module tb_id_exe_stage;

    localparam int CNT_W   = 4;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        stage_rst = 1'b0, stage_en = 1'b0, in_valid = 1'b0, cnt_clr = 1'b0;
    logic [31:0] in_inst = '0, in_pc = '0, in_data_rs = '0, in_data_rt = '0, in_data_imm = '0;
    logic [2:0]  in_pc_src = '0;
    logic [1:0]  in_exe_a_src = '0, in_exe_b_src = '0, in_wb_addr_src = '0;
    logic [3:0]  in_exe_alu_oper = '0;
    logic        in_mem_ren = 1'b0, in_mem_wen = 1'b0, in_wb_data_src = 1'b0, in_wb_wen = 1'b0;

    logic [31:0] out_inst, out_pc, out_data_rs, out_data_rt, out_data_imm;
    logic [2:0]  out_pc_src;
    logic [1:0]  out_exe_a_src, out_exe_b_src, out_wb_addr_src;
    logic [3:0]  out_exe_alu_oper;
    logic        out_mem_ren, out_mem_wen, out_wb_data_src, out_wb_wen;
    logic        exe_valid, wb_wen_exe, is_branch_exe;
    logic [4:0]  regw_addr_exe;
    logic [CNT_W-1:0] bubble_cnt, hold_cnt;

    id_exe_stage #(.CNT_WIDTH(CNT_W), .LINK_REG(31)) dut (
        .clk(clk), .rst(rst), .stage_rst(stage_rst), .stage_en(stage_en), .in_valid(in_valid),
        .in_inst(in_inst), .in_pc(in_pc), .in_data_rs(in_data_rs), .in_data_rt(in_data_rt),
        .in_data_imm(in_data_imm), .in_pc_src(in_pc_src), .in_exe_a_src(in_exe_a_src),
        .in_exe_b_src(in_exe_b_src), .in_exe_alu_oper(in_exe_alu_oper), .in_mem_ren(in_mem_ren),
        .in_mem_wen(in_mem_wen), .in_wb_addr_src(in_wb_addr_src), .in_wb_data_src(in_wb_data_src),
        .in_wb_wen(in_wb_wen), .cnt_clr(cnt_clr),
        .out_inst(out_inst), .out_pc(out_pc), .out_data_rs(out_data_rs), .out_data_rt(out_data_rt),
        .out_data_imm(out_data_imm), .out_pc_src(out_pc_src), .out_exe_a_src(out_exe_a_src),
        .out_exe_b_src(out_exe_b_src), .out_exe_alu_oper(out_exe_alu_oper),
        .out_mem_ren(out_mem_ren), .out_mem_wen(out_mem_wen), .out_wb_addr_src(out_wb_addr_src),
        .out_wb_data_src(out_wb_data_src), .out_wb_wen(out_wb_wen), .exe_valid(exe_valid),
        .regw_addr_exe(regw_addr_exe), .wb_wen_exe(wb_wen_exe), .is_branch_exe(is_branch_exe),
        .bubble_cnt(bubble_cnt), .hold_cnt(hold_cnt)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference state: the instruction currently held in EXE (fields packed as one word list).
    logic [31:0] m_inst, m_pc, m_rs, m_rt, m_imm;
    logic [2:0]  m_pc_src;
    logic [1:0]  m_a, m_b, m_wbas;
    logic [3:0]  m_alu;
    logic        m_mren, m_mwen, m_wbds, m_wbwen, m_valid;
    int          m_bub, m_hold;

    function automatic logic [4:0] dest_reg(input logic [1:0] src, input logic [31:0] inst);
        if (src == 2'd0) return inst[15:11];
        if (src == 2'd1) return inst[20:16];
        if (src == 2'd2) return 5'd31;
        return 5'd0;
    endfunction

    task automatic model_clear_stage();
        {m_inst, m_pc, m_rs, m_rt, m_imm} = '0;
        {m_pc_src, m_a, m_b, m_wbas, m_alu} = '0;
        {m_mren, m_mwen, m_wbds, m_wbwen, m_valid} = '0;
    endtask

    // Apply one rising edge of the spec's rules to the model, using the inputs present at the edge.
    task automatic model_edge();
        if (stage_rst) begin
            model_clear_stage();
        end else if (stage_en) begin
            m_inst = in_inst; m_pc = in_pc; m_rs = in_data_rs; m_rt = in_data_rt; m_imm = in_data_imm;
            m_pc_src = in_pc_src; m_a = in_exe_a_src; m_b = in_exe_b_src; m_alu = in_exe_alu_oper;
            m_mren = in_mem_ren; m_mwen = in_mem_wen; m_wbas = in_wb_addr_src;
            m_wbds = in_wb_data_src; m_wbwen = in_wb_wen; m_valid = in_valid;
        end
        if (cnt_clr) begin
            m_bub = 0; m_hold = 0;
        end else if (stage_rst || (stage_en && !in_valid)) begin
            m_bub = (m_bub < CNT_MAX) ? m_bub + 1 : CNT_MAX;
        end else if (!stage_en) begin
            m_hold = (m_hold < CNT_MAX) ? m_hold + 1 : CNT_MAX;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ":exe_valid"}, 32'(exe_valid), 32'(m_valid));
        chk({tag, ":regw"}, 32'(regw_addr_exe), m_valid || m_wbas != 0 || m_inst != 0 ? 32'(dest_reg(m_wbas, m_inst)) : 32'd0);
        chk({tag, ":wb_wen_exe"}, 32'(wb_wen_exe), 32'(m_valid && m_wbwen));
        chk({tag, ":is_branch"}, 32'(is_branch_exe), 32'(m_valid && (m_pc_src != 3'd0)));
        chk({tag, ":bubble_cnt"}, 32'(bubble_cnt), 32'(m_bub));
        chk({tag, ":hold_cnt"}, 32'(hold_cnt), 32'(m_hold));
        chk({tag, ":inst"}, out_inst, m_inst);
        chk({tag, ":pc"}, out_pc, m_pc);
        chk({tag, ":rs"}, out_data_rs, m_rs);
        chk({tag, ":rt"}, out_data_rt, m_rt);
        chk({tag, ":imm"}, out_data_imm, m_imm);
        chk({tag, ":ctrl"},
            {14'd0, out_pc_src, out_exe_a_src, out_exe_b_src, out_exe_alu_oper, out_mem_ren,
             out_mem_wen, out_wb_addr_src, out_wb_data_src, out_wb_wen},
            {14'd0, m_pc_src, m_a, m_b, m_alu, m_mren, m_mwen, m_wbas, m_wbds, m_wbwen});
    endtask

    task automatic cycle(input string tag);
        @(posedge clk);
        model_edge();
        #1;
        check_all(tag);
    endtask

    task automatic rand_fields();
        in_inst = $urandom; in_pc = $urandom; in_data_rs = $urandom;
        in_data_rt = $urandom; in_data_imm = $urandom;
        in_pc_src = 3'($urandom_range(0, 4)); in_exe_a_src = 2'($urandom);
        in_exe_b_src = 2'($urandom); in_exe_alu_oper = 4'($urandom);
        in_mem_ren = 1'($urandom); in_mem_wen = 1'($urandom);
        in_wb_addr_src = 2'($urandom); in_wb_data_src = 1'($urandom);
        in_wb_wen = 1'($urandom); in_valid = 1'($urandom);
    endtask

    task automatic ctrl(input logic srst, input logic en, input logic vld, input logic clr);
        stage_rst = srst; stage_en = en; in_valid = vld; cnt_clr = clr;
    endtask

    initial begin
        model_clear_stage();
        m_bub = 0; m_hold = 0;
        rand_fields();
        #12;
        check_all("reset_hold");
        rst = 1'b1;

        // add $3,$1,$2 with write-back to rd
        rand_fields();
        in_inst = 32'h0022_1820; in_pc_src = 3'd0; in_wb_addr_src = 2'd0; in_wb_wen = 1'b1;
        ctrl(1'b0, 1'b1, 1'b1, 1'b0);
        cycle("add");
        chk("add:regw_const", 32'(regw_addr_exe), 32'd3);
        chk("add:wb_wen_const", 32'(wb_wen_exe), 32'd1);
        chk("add:branch_const", 32'(is_branch_exe), 32'd0);

        // beq fields with stage reset and enable together: reset wins
        rand_fields();
        in_inst = 32'h1022_0004; in_pc_src = 3'd3; in_wb_wen = 1'b0;
        ctrl(1'b1, 1'b1, 1'b1, 1'b0);
        cycle("prio");
        chk("prio:valid_const", 32'(exe_valid), 32'd0);
        chk("prio:bubble_const", 32'(bubble_cnt), 32'd1);

        // jal, counters cleared on the same edge
        rand_fields();
        in_inst = 32'h0C00_0010; in_pc_src = 3'd1; in_wb_addr_src = 2'd2; in_wb_wen = 1'b1;
        ctrl(1'b0, 1'b1, 1'b1, 1'b1);
        cycle("jal");
        chk("jal:regw_const", 32'(regw_addr_exe), 32'd31);
        chk("jal:branch_const", 32'(is_branch_exe), 32'd1);

        for (int i = 0; i < 3; i++) begin
            rand_fields();
            ctrl(1'b0, 1'b0, 1'($urandom), 1'b0);
            cycle("hold");
        end
        chk("hold:cnt_const", 32'(hold_cnt), 32'd3);
        chk("hold:regw_const", 32'(regw_addr_exe), 32'd31);

        // captured-invalid entry must not raise hazards
        rand_fields();
        in_wb_wen = 1'b1; in_pc_src = 3'd3;
        ctrl(1'b0, 1'b1, 1'b0, 1'b0);
        cycle("invalid");
        chk("invalid:wb_wen_const", 32'(wb_wen_exe), 32'd0);
        chk("invalid:branch_const", 32'(is_branch_exe), 32'd0);
        chk("invalid:bubble_const", 32'(bubble_cnt), 32'd1);

        ctrl(1'b0, 1'b1, 1'b1, 1'b1);
        cycle("sat_clr");
        for (int i = 0; i < 20; i++) begin
            rand_fields();
            ctrl(1'($urandom), 1'b1, 1'b0, 1'b0);
            cycle("sat");
        end
        chk("sat:bubble_const", 32'(bubble_cnt), 32'd15);
        ctrl(1'b1, 1'b0, 1'b0, 1'b1);
        cycle("clr_wins");
        chk("clr_wins:bubble_const", 32'(bubble_cnt), 32'd0);

        for (int i = 0; i < 300; i++) begin
            rand_fields();
            ctrl(($urandom_range(0, 7) == 0), ($urandom_range(0, 3) != 0), in_valid,
                 ($urandom_range(0, 15) == 0));
            cycle("rand");
        end

        // asynchronous reset while a valid entry is held
        rand_fields();
        in_pc_src = 3'd1;
        ctrl(1'b0, 1'b1, 1'b1, 1'b0);
        cycle("pre_rst");
        chk("pre_rst:valid_const", 32'(exe_valid), 32'd1);
        #2;
        rst = 1'b0;
        #1;
        model_clear_stage();
        m_bub = 0; m_hold = 0;
        check_all("async_rst");
        #3;
        rst = 1'b1;
        rand_fields();
        ctrl(1'b0, 1'b1, 1'b1, 1'b0);
        cycle("post_rst");
        chk("post_rst:valid_const", 32'(exe_valid), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
